i2c_target_phy: RTL and testbench
=================================

Name: i2c_target_phy

Overview:
- Byte-level I2C target (slave) engine; it sits on the far side of the bus from the master bit PHY, i2c_phy.
- Samples scl_i/sda_i, detects START/STOP, matches a 7-bit address and ACKs it, receives write bytes, and serves read bytes.
- Drives SDA, and SCL for clock stretching, through the same _o/_t open-drain pin pairs the master PHY uses.
- Provides a valid/ready byte interface to a register file or FIFO.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit bus address this target responds to.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- scl_i  in  1  SCL pin level
- sda_i  in  1  SDA pin level
- scl_o  out  1  SCL drive value (0 = pull low)
- scl_t  out  1  SCL tristate (1 = released)
- sda_o  out  1  SDA drive value (0 = pull low)
- sda_t  out  1  SDA tristate (1 = released)
- rx_data  out  8  last received write byte
- rx_valid  out  1  one-cycle pulse, rx_data valid
- tx_data  in  8  byte to return on a read
- tx_valid  in  1  tx_data available
- tx_ready  out  1  target requests a read byte
- rw  out  1  R/W bit of the current transaction (1 = read)
- busy  out  1  addressed, transaction in progress
- start_det  out  1  one-cycle pulse on START or repeated START
- stop_det  out  1  one-cycle pulse on STOP

Behaviour:
- Reset values: scl_o=1, scl_t=1, sda_o=1, sda_t=1, rx_data=0, rx_valid=0, tx_ready=0, rw=0, busy=0, start_det=0, stop_det=0; state=IDLE.
- Pin drive invariant: sda_o=0 exactly when sda_t=0; likewise for SCL.
- Input synchronisation: scl_i and sda_i each pass through a 2-FF synchroniser. All edges are detected from the synchronised value versus its one-cycle-delayed copy.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognised in any state, including mid-byte.
  - START: pulse start_det, clear bit counter, go to ADDR, release SDA.
  - STOP: pulse stop_det, go to IDLE, release SDA and SCL, busy=0.
- Data bits: sampled on the SCL rising edge, MSB first. SDA is changed by the target only in the cycle the SCL falling edge is detected.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. After the 8th rising edge, compare [7:1] with TARGET_ADDR.
    - Match: latch rw=bit0, busy=1, go to ADDR_ACK.
    - Mismatch: go to IGNORE.
  - ADDR_ACK: on the next falling edge drive SDA low; on the following falling edge:
    - rw=0: release SDA, go to WRITE.
    - rw=1: go to READ_LOAD.
  - WRITE: shift 8 bits. At the 8th rising edge, rx_data is updated and rx_valid pulses for one clk in the cycle after detection. Go to WRITE_ACK.
  - WRITE_ACK: drive SDA low on the next falling edge; release on the following falling edge; return to WRITE. Every write byte is ACKed.
  - READ_LOAD: tx_ready=1; SCL is held low (scl_o=0, scl_t=0) until tx_valid&&tx_ready.
    - In the transfer cycle, load the shift register, drive sda_o=tx_data[7] (released if 1), deassert tx_ready, release SCL, go to READ.
  - READ: on each of the next 7 falling edges present the next bit. On the 8th falling edge release SDA and go to READ_ACK.
  - READ_ACK: sample SDA at the 9th rising edge.
    - 0 (ACK): on the following falling edge go to READ_LOAD.
    - 1 (NACK): go to IGNORE.
  - IGNORE: SDA and SCL released; wait for START or STOP.
- Byte values are 1 = released (high-Z), 0 = driven low. Never drive a 1.
- Stretch release: once SCL is released, the next bit is shifted only after the master's SCL rises.
- Repeated START during any state aborts the byte silently: no rx_valid for a partial byte; busy stays 1 until address re-evaluation.
- Reset mid-transfer forces reset values immediately, asynchronously; the bus is released in the same instant.

Test Plan:
- Write: START, 0xA0, 0x3C, 0xC3, STOP → target ACKs all three bytes (SDA low on 9th clocks). rx_valid pulses twice with 0x3C then 0xC3. start_det and stop_det pulse once each. rw=0.
- Read with stretch: START, 0xA1, tx_valid withheld 20 clks → SCL held low ≥20 clks, tx_ready=1. Provide 0x5A then 0x81; master ACKs byte 1 and NACKs byte 2 → bus carries 0x5A, 0x81; state is IGNORE after the NACK.
- Address mismatch: START, 0xA2, 0x11, STOP → SDA never driven, busy=0, no rx_valid.
- Repeated START: START, 0xA0, 0x10, Sr, 0xA1, read one byte 0x77 → rw transitions 0→1, data 0x77 returned, exactly one rx_valid (0x10).
- STOP mid-byte: START, 0xA0, 4 bits of data, STOP → no rx_valid, state IDLE, busy=0, sda_t=1.
- Reset during READ with SDA low → sda_t=1, scl_t=1 and all outputs at reset values in the same cycle; next START is recognised normally.

Source files
------------

// File: rtl/i2c_target_phy_if.sv
// rtl/i2c_target_phy_if.sv - pin and byte-stream bundle for the I2C target engine
//
// Ports (slave = target engine side, master = bus/host side):
//   scl_i, sda_i        pin levels seen on the bus
//   scl_o/scl_t         SCL drive value / tristate (1 = released)
//   sda_o/sda_t         SDA drive value / tristate (1 = released)
//   rx_data, rx_valid   received write byte, one-cycle valid pulse
//   tx_data, tx_valid   byte offered for a read
//   tx_ready            target requests a read byte
//   rw, busy            R/W bit of the transaction, addressed flag
//   start_det, stop_det one-cycle START / STOP pulses

interface i2c_target_phy_if;
  logic       scl_i;
  logic       sda_i;
  logic       scl_o;
  logic       scl_t;
  logic       sda_o;
  logic       sda_t;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       rw;
  logic       busy;
  logic       start_det;
  logic       stop_det;

  modport slave (
    input  scl_i, sda_i, tx_data, tx_valid,
    output scl_o, scl_t, sda_o, sda_t, rx_data, rx_valid,
           tx_ready, rw, busy, start_det, stop_det
  );

  modport master (
    output scl_i, sda_i, tx_data, tx_valid,
    input  scl_o, scl_t, sda_o, sda_t, rx_data, rx_valid,
           tx_ready, rw, busy, start_det, stop_det
  );
endinterface

// File: rtl/i2c_target_phy.sv
// rtl/i2c_target_phy.sv - byte-level I2C target engine with clock stretching
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   i2c_target_phy_if.slave: open-drain SCL/SDA pin pairs plus the
//         rx (write) / tx (read) byte handshake and status pulses
// Parameter:
//   TARGET_ADDR  7-bit address this target answers to

module i2c_target_phy #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input logic             clk,
  input logic             rst,
  i2c_target_phy_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WRITE_ACK,
    S_READ_LOAD,
    S_READ,
    S_READ_ACK,
    S_IGNORE
  } state_e;

  // Synchronisers; reset to 1 so the idle bus produces no edge after reset.
  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic       phase_q, phase_d;      // first/second edge inside an ACK slot
  logic       sda_low_q, sda_low_d;
  logic       scl_low_q, scl_low_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_ready_q, tx_ready_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;

  logic       scl_rise, scl_fall, sda_rise, sda_fall;
  logic       start_ev, stop_ev;
  logic [7:0] shift_in;

  assign scl_rise = scl_sync_q & ~scl_prev_q;
  assign scl_fall = ~scl_sync_q & scl_prev_q;
  assign sda_rise = sda_sync_q & ~sda_prev_q;
  assign sda_fall = ~sda_sync_q & sda_prev_q;
  // SCL must be high in both samples so an SDA change right at SCL fall is data
  assign start_ev = sda_fall & scl_sync_q & scl_prev_q;
  assign stop_ev  = sda_rise & scl_sync_q & scl_prev_q;
  assign shift_in = {shift_q[6:0], sda_sync_q};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta_q  <= 1'b1;
      scl_sync_q  <= 1'b1;
      scl_prev_q  <= 1'b1;
      sda_meta_q  <= 1'b1;
      sda_sync_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      shift_q     <= 8'h00;
      bitcnt_q    <= 4'd0;
      phase_q     <= 1'b0;
      sda_low_q   <= 1'b0;
      scl_low_q   <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      scl_meta_q  <= bus.scl_i;
      scl_sync_q  <= scl_meta_q;
      scl_prev_q  <= scl_sync_q;
      sda_meta_q  <= bus.sda_i;
      sda_sync_q  <= sda_meta_q;
      sda_prev_q  <= sda_sync_q;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      phase_q     <= phase_d;
      sda_low_q   <= sda_low_d;
      scl_low_q   <= scl_low_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_ready_q  <= tx_ready_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    phase_d     = phase_q;
    sda_low_d   = sda_low_q;
    scl_low_d   = scl_low_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_ready_d  = tx_ready_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;

    if (stop_ev) begin
      stop_det_d = 1'b1;
      state_d    = S_IDLE;
      sda_low_d  = 1'b0;
      scl_low_d  = 1'b0;
      tx_ready_d = 1'b0;
      busy_d     = 1'b0;
    end else if (start_ev) begin
      // busy is left alone: a repeated START keeps it until the new address
      start_det_d = 1'b1;
      state_d     = S_ADDR;
      bitcnt_d    = 4'd0;
      phase_d     = 1'b0;
      sda_low_d   = 1'b0;
      scl_low_d   = 1'b0;
      tx_ready_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
        end

        S_ADDR: begin
          if (scl_rise) begin
            shift_d  = shift_in;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              if (shift_in[7:1] == TARGET_ADDR) begin
                rw_d    = shift_in[0];
                busy_d  = 1'b1;
                phase_d = 1'b0;
                state_d = S_ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = S_IGNORE;
              end
            end
          end
        end

        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_low_d = 1'b1;
              phase_d   = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bitcnt_d  = 4'd0;
              sda_low_d = 1'b0;
              if (rw_q) begin
                scl_low_d  = 1'b1;
                tx_ready_d = 1'b1;
                state_d    = S_READ_LOAD;
              end else begin
                state_d = S_WRITE;
              end
            end
          end
        end

        S_WRITE: begin
          if (scl_rise) begin
            shift_d  = shift_in;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
              phase_d    = 1'b0;
              state_d    = S_WRITE_ACK;
            end
          end
        end

        S_WRITE_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_low_d = 1'b1;
              phase_d   = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              phase_d   = 1'b0;
              bitcnt_d  = 4'd0;
              state_d   = S_WRITE;
            end
          end
        end

        S_READ_LOAD: begin
          // SCL is held low here, so SDA may change in the transfer cycle
          if (bus.tx_valid && tx_ready_q) begin
            shift_d    = bus.tx_data;
            sda_low_d  = ~bus.tx_data[7];
            tx_ready_d = 1'b0;
            scl_low_d  = 1'b0;
            bitcnt_d   = 4'd0;
            state_d    = S_READ;
          end
        end

        S_READ: begin
          if (scl_fall) begin
            if (bitcnt_q == 4'd7) begin
              sda_low_d = 1'b0;
              phase_d   = 1'b0;
              state_d   = S_READ_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b1};
              sda_low_d = ~shift_q[6];
              bitcnt_d  = bitcnt_q + 4'd1;
            end
          end
        end

        S_READ_ACK: begin
          if (!phase_q) begin
            if (scl_rise) begin
              if (sda_sync_q) begin
                state_d = S_IGNORE;
              end else begin
                phase_d = 1'b1;
              end
            end
          end else if (scl_fall) begin
            phase_d    = 1'b0;
            scl_low_d  = 1'b1;
            tx_ready_d = 1'b1;
            state_d    = S_READ_LOAD;
          end
        end

        S_IGNORE: begin
          sda_low_d = 1'b0;
          scl_low_d = 1'b0;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs: pins are only ever pulled low or released, never driven high
  always_comb begin
    bus.sda_o     = ~sda_low_q;
    bus.sda_t     = ~sda_low_q;
    bus.scl_o     = ~scl_low_q;
    bus.scl_t     = ~scl_low_q;
    bus.rx_data   = rx_data_q;
    bus.rx_valid  = rx_valid_q;
    bus.tx_ready  = tx_ready_q;
    bus.rw        = rw_q;
    bus.busy      = busy_q;
    bus.start_det = start_det_q;
    bus.stop_det  = stop_det_q;
  end

endmodule

// File: tb/tb_i2c_target_phy.sv
// tb/tb_i2c_target_phy.sv - self-checking bench for i2c_target_phy
`timescale 1ns/1ps

module tb_i2c_target_phy;
  localparam int TQ = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  always #5 clk = ~clk;

  i2c_target_phy_if bus_if ();

  assign bus_if.scl_i = scl_m & (bus_if.scl_t | bus_if.scl_o);
  assign bus_if.sda_i = sda_m & (bus_if.sda_t | bus_if.sda_o);

  i2c_target_phy #(.TARGET_ADDR(7'h50)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_ack;
  } wr_vec_t;

  typedef struct {
    logic [7:0] data;
    int         delay;
  } tx_item_t;

  int n_checks = 0;
  int n_pass = 0;
  int rx_cnt = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  int sda_drive_cnt = 0;
  int hold_run = 0;
  int hold_max = 0;
  int ready_hold_cnt = 0;
  int inv_err = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_rd_q[$];
  tx_item_t   tx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Output monitors, sampled on the falling clock edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.rx_valid) begin
        rx_cnt++;
        if (exp_rx_q.size() == 0) begin
          n_checks++;
          $display("FAIL rx_unexpected: got %0h, required no rx_valid", bus_if.rx_data);
        end else begin
          check("rx_data", bus_if.rx_data, exp_rx_q.pop_front());
        end
      end
      if (bus_if.start_det) start_cnt++;
      if (bus_if.stop_det) stop_cnt++;
      if (!bus_if.sda_t) sda_drive_cnt++;
      if (!bus_if.scl_t) begin
        hold_run++;
        if (hold_run > hold_max) hold_max = hold_run;
        if (bus_if.tx_ready) ready_hold_cnt++;
      end else begin
        hold_run = 0;
      end
    end
    if ((bus_if.sda_o != bus_if.sda_t) || (bus_if.scl_o != bus_if.scl_t)) inv_err++;
  end

  // Read-byte provider: answers tx_ready after a per-item delay
  initial begin
    tx_item_t it;
    bus_if.tx_valid = 1'b0;
    bus_if.tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && bus_if.tx_ready && tx_q.size() > 0) begin
        it = tx_q.pop_front();
        wait_clks(it.delay);
        bus_if.tx_data  = it.data;
        bus_if.tx_valid = 1'b1;
        exp_rd_q.push_back(it.data);
        @(negedge clk);
        bus_if.tx_valid = 1'b0;
      end
    end
  end

  task automatic clk_bit(input logic b, output logic r, output int stretch);
    sda_m = b;
    wait_clks(TQ);
    scl_m = 1'b1;
    stretch = 0;
    while (!bus_if.scl_i && stretch < 400) begin
      @(negedge clk);
      stretch++;
    end
    if (stretch >= 400) begin
      n_checks++;
      $display("FAIL scl_release: SCL low after %0d clks, required high", stretch);
    end
    wait_clks(TQ);
    r = bus_if.sda_i;
    wait_clks(TQ);
    scl_m = 1'b0;
    wait_clks(TQ);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clks(TQ);
    scl_m = 1'b1;
    wait_clks(TQ);
    sda_m = 1'b0;
    wait_clks(TQ);
    scl_m = 1'b0;
    wait_clks(TQ);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clks(TQ);
    scl_m = 1'b1;
    wait_clks(TQ);
    sda_m = 1'b1;
    wait_clks(TQ);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    int s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], r, s);
    clk_bit(1'b1, r, s);
    ack = ~r;
  endtask

  task automatic read_byte(input logic ack_it, output logic [7:0] d);
    logic r;
    int s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r, s);
      d[i] = r;
    end
    clk_bit(~ack_it, r, s);
  endtask

  task automatic check_read(input string name, input logic [7:0] d);
    if (exp_rd_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got %0h, required a provided byte", name, d);
    end else begin
      check(name, d, exp_rd_q.pop_front());
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    wr_vec_t    vecs[8];
    logic       ack;
    logic [7:0] d;
    logic       r;
    int         s, rx0, st0, sp0, drv0;

    vecs[0] = '{8'hA0, 8'h3C, 1'b1};
    vecs[1] = '{8'hA0, 8'hC3, 1'b1};
    vecs[2] = '{8'hA2, 8'h11, 1'b0};
    vecs[3] = '{8'hA0, 8'h00, 1'b1};
    vecs[4] = '{8'hA0, 8'hFF, 1'b1};
    vecs[5] = '{8'h20, 8'h55, 1'b0};
    vecs[6] = '{8'hB0, 8'hAA, 1'b0};
    vecs[7] = '{8'hA4, 8'h5A, 1'b0};

    // Reset values
    wait_clks(4);
    check("reset_pins", {bus_if.sda_o, bus_if.sda_t, bus_if.scl_o, bus_if.scl_t}, 4'hF);
    check("reset_status", {bus_if.rx_data, bus_if.rx_valid, bus_if.tx_ready, bus_if.rw,
                           bus_if.busy, bus_if.start_det, bus_if.stop_det}, 14'h0);
    rst = 1'b0;
    wait_clks(10);
    check("post_reset_idle", {bus_if.sda_t, bus_if.scl_t, bus_if.busy}, 3'b110);

    // Single-byte write table
    for (int v = 0; v < 8; v++) begin
      rx0 = rx_cnt;
      drv0 = sda_drive_cnt;
      i2c_start();
      write_byte(vecs[v].addr, ack);
      check($sformatf("vec%0d_addr_ack", v), ack, vecs[v].exp_ack);
      check($sformatf("vec%0d_busy", v), bus_if.busy, vecs[v].exp_ack);
      if (vecs[v].exp_ack) exp_rx_q.push_back(vecs[v].data);
      write_byte(vecs[v].data, ack);
      check($sformatf("vec%0d_data_ack", v), ack, vecs[v].exp_ack);
      i2c_stop();
      wait_clks(4);
      check($sformatf("vec%0d_busy_end", v), bus_if.busy, 1'b0);
      check($sformatf("vec%0d_rx_count", v), rx_cnt - rx0, {31'd0, vecs[v].exp_ack});
      if (!vecs[v].exp_ack) check($sformatf("vec%0d_sda_idle", v), sda_drive_cnt - drv0, 0);
    end

    // Multi-byte write
    rx0 = rx_cnt; st0 = start_cnt; sp0 = stop_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("mw_addr_ack", ack, 1'b1);
    exp_rx_q.push_back(8'h3C);
    write_byte(8'h3C, ack);
    check("mw_ack1", ack, 1'b1);
    exp_rx_q.push_back(8'hC3);
    write_byte(8'hC3, ack);
    check("mw_ack2", ack, 1'b1);
    check("mw_rw", bus_if.rw, 1'b0);
    i2c_stop();
    wait_clks(4);
    check("mw_rx_count", rx_cnt - rx0, 2);
    check("mw_start_cnt", start_cnt - st0, 1);
    check("mw_stop_cnt", stop_cnt - sp0, 1);

    // Read with stretch, ACK then NACK
    hold_max = 0; ready_hold_cnt = 0;
    tx_q.push_back('{8'h5A, 20});
    tx_q.push_back('{8'h81, 3});
    i2c_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", ack, 1'b1);
    check("rd_rw_busy", {bus_if.rw, bus_if.busy}, 2'b11);
    read_byte(1'b1, d);
    check_read("rd_byte0", d);
    check("rd_stretch_len", hold_max >= 20, 1'b1);
    check("rd_ready_during_hold", ready_hold_cnt >= 20, 1'b1);
    read_byte(1'b0, d);
    check_read("rd_byte1", d);
    drv0 = sda_drive_cnt;
    wait_clks(40);
    check("rd_ignore_released", {bus_if.tx_ready, bus_if.sda_t, bus_if.scl_t}, 3'b011);
    check("rd_ignore_sda_idle", sda_drive_cnt - drv0, 0);
    i2c_stop();
    wait_clks(4);
    check("rd_busy_end", bus_if.busy, 1'b0);

    // Repeated START: write then read
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("sr_addr0_ack", ack, 1'b1);
    check("sr_rw0", bus_if.rw, 1'b0);
    exp_rx_q.push_back(8'h10);
    write_byte(8'h10, ack);
    check("sr_data_ack", ack, 1'b1);
    i2c_start();
    check("sr_busy_held", bus_if.busy, 1'b1);
    tx_q.push_back('{8'h77, 2});
    write_byte(8'hA1, ack);
    check("sr_addr1_ack", ack, 1'b1);
    check("sr_rw1", bus_if.rw, 1'b1);
    read_byte(1'b0, d);
    check_read("sr_rd_byte", d);
    i2c_stop();
    wait_clks(4);
    check("sr_rx_count", rx_cnt - rx0, 1);

    // STOP in the middle of a write byte
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("mid_addr_ack", ack, 1'b1);
    clk_bit(1'b1, r, s);
    clk_bit(1'b0, r, s);
    clk_bit(1'b1, r, s);
    clk_bit(1'b1, r, s);
    i2c_stop();
    wait_clks(6);
    check("mid_rx_count", rx_cnt - rx0, 0);
    check("mid_busy_sda", {bus_if.busy, bus_if.sda_t, bus_if.tx_ready}, 3'b010);

    // Reset while the target drives SDA low during a read
    tx_q.push_back('{8'h00, 2});
    i2c_start();
    write_byte(8'hA1, ack);
    check("rst_addr_ack", ack, 1'b1);
    clk_bit(1'b1, r, s);
    check("rst_bit7", r, 1'b0);
    @(negedge clk);
    check("rst_pre_sda_low", bus_if.sda_t, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_outputs", {bus_if.sda_o, bus_if.sda_t, bus_if.scl_o, bus_if.scl_t,
                                bus_if.rx_valid, bus_if.tx_ready, bus_if.rw, bus_if.busy,
                                bus_if.start_det, bus_if.stop_det}, 10'b1111_000000);
    scl_m = 1'b1;
    wait_clks(2);
    sda_m = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    exp_rd_q.delete();
    wait_clks(10);
    st0 = start_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("post_rst_addr_ack", ack, 1'b1);
    exp_rx_q.push_back(8'h42);
    write_byte(8'h42, ack);
    check("post_rst_data_ack", ack, 1'b1);
    i2c_stop();
    wait_clks(4);
    check("post_rst_start_cnt", start_cnt - st0, 1);

    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("pin_invariant", inv_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
